multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl_pkg.sv | 27 ++
 rtl/multicycle_ctrl_if.sv | 9 +
 rtl/multicycle_ctrl_timeout.sv | 17 +
 rtl/multicycle_ctrl.sv | 156 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_ctrl_pkg: shared states, opcode/funct constants and datapath select encodings.
package multicycle_ctrl_pkg;
    typedef enum logic [3:0] {
        FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR,
        WB_ALU, WB_MEM, BRANCH, JUMP, TRAP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] FN_JR    = 6'd8;

    localparam logic [1:0] SRCB_RT = 2'd0, SRCB_FOUR = 2'd1, SRCB_IMM = 2'd2, SRCB_IMM_SH = 2'd3;
    localparam logic [1:0] PC_ALU = 2'd0, PC_ALUOUT = 2'd1, PC_JUMP = 2'd2, PC_RS = 2'd3;
    localparam logic [1:0] DST_RT = 2'd0, DST_RD = 2'd1, DST_RA = 2'd2;
    localparam logic [1:0] WD_ALU = 2'd0, WD_MEM = 2'd1, WD_PC = 2'd3;
    localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_FUNCT = 3'd2;

    function automatic logic is_wait(state_t s);
        return s inside {FETCH, MEM_RD, MEM_WR};
    endfunction
endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: memory request/ready handshake between controller and memory.
interface multicycle_ctrl_if;
    logic mem_read_o;
    logic mem_write_o;
    logic iord_o;
    logic mem_ready_i;
    modport master (output mem_read_o, mem_write_o, iord_o, input mem_ready_i);
    modport slave  (input mem_read_o, mem_write_o, iord_o, output mem_ready_i);
endinterface

// File: rtl/multicycle_ctrl_timeout.sv
// mc_timeout: memory-wait cycle counter; expired is high once the count saturates.
module mc_timeout #(
    parameter int W = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr,
    input  logic inc,
    output logic expired
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (inc) cnt <= cnt + 1'b1;
    assign expired = &cnt;
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle MIPS-style control FSM with memory-wait timeout trap.
// Define MULTICYCLE_CTRL_PERF_EN to build the cycle/instruction counters.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int TIMEOUT_W = 4,
    parameter int CNT_W     = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    multicycle_ctrl_if.master mem,
    input  logic [5:0]       opcode_i,
    input  logic [5:0]       funct_i,
    input  logic             zero_i,
    output logic             ir_write_o,
    output logic             pc_write_o,
    output logic             reg_write_o,
    output logic             alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [2:0]       alu_op_o,
    output logic [1:0]       pc_src_o,
    output logic [1:0]       reg_dst_o,
    output logic [1:0]       mem_to_reg_o,
    output logic             err_o,
    output logic [CNT_W-1:0] cyc_cnt_o,
    output logic [CNT_W-1:0] ins_cnt_o
);
    state_t state, next;
    logic ready, waiting, expired;

    assign ready   = mem.mem_ready_i;
    assign waiting = is_wait(state);

    // clearing on ready or outside a wait state is equivalent to clearing on wait-state entry
    mc_timeout #(.W(TIMEOUT_W)) u_timeout (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr     (!waiting || ready),
        .inc     (waiting && !ready),
        .expired (expired)
    );

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) state <= FETCH;
        else state <= next;

    always_comb begin
        next            = state;
        mem.mem_read_o  = 1'b0;
        mem.mem_write_o = 1'b0;
        mem.iord_o      = 1'b0;
        ir_write_o      = 1'b0;
        pc_write_o      = 1'b0;
        reg_write_o     = 1'b0;
        alu_src_a_o     = 1'b0;
        alu_src_b_o     = SRCB_RT;
        alu_op_o        = ALU_ADD;
        pc_src_o        = PC_ALU;
        reg_dst_o       = DST_RT;
        mem_to_reg_o    = WD_ALU;
        err_o           = 1'b0;
        // outputs are gated by reset so a pending request drops immediately
        if (!rst_i)
            case (state)
                FETCH: begin
                    mem.mem_read_o = 1'b1;
                    alu_src_b_o    = SRCB_FOUR;
                    ir_write_o     = ready;
                    pc_write_o     = ready;
                    next           = ready ? DECODE : expired ? TRAP : FETCH;
                end
                DECODE: begin
                    alu_src_b_o = SRCB_IMM_SH;
                    case (opcode_i)
                        OP_RTYPE:      next = EXEC_R;
                        OP_LW, OP_SW:  next = MEM_ADDR;
                        OP_ADDI:       next = EXEC_I;
                        OP_BEQ, OP_BNE: next = BRANCH;
                        OP_J, OP_JAL:  next = JUMP;
                        default:       next = TRAP;
                    endcase
                end
                EXEC_R: begin
                    alu_src_a_o = 1'b1;
                    alu_op_o    = ALU_FUNCT;
                    pc_write_o  = funct_i == FN_JR;
                    pc_src_o    = PC_RS;
                    next        = funct_i == FN_JR ? FETCH : WB_ALU;
                end
                EXEC_I: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = SRCB_IMM;
                    next        = WB_ALU;
                end
                MEM_ADDR: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = SRCB_IMM;
                    next        = opcode_i == OP_SW ? MEM_WR : MEM_RD;
                end
                MEM_RD: begin
                    mem.mem_read_o = 1'b1;
                    mem.iord_o     = 1'b1;
                    next           = ready ? WB_MEM : expired ? TRAP : MEM_RD;
                end
                MEM_WR: begin
                    mem.mem_write_o = 1'b1;
                    mem.iord_o      = 1'b1;
                    next            = ready ? FETCH : expired ? TRAP : MEM_WR;
                end
                WB_ALU: begin
                    reg_write_o = 1'b1;
                    reg_dst_o   = opcode_i == OP_RTYPE ? DST_RD : DST_RT;
                    next        = FETCH;
                end
                WB_MEM: begin
                    reg_write_o  = 1'b1;
                    mem_to_reg_o = WD_MEM;
                    next         = FETCH;
                end
                BRANCH: begin
                    alu_src_a_o = 1'b1;
                    alu_op_o    = ALU_SUB;
                    pc_src_o    = PC_ALUOUT;
                    pc_write_o  = (opcode_i == OP_BEQ && zero_i) || (opcode_i == OP_BNE && !zero_i);
                    next        = FETCH;
                end
                JUMP: begin
                    pc_write_o   = 1'b1;
                    pc_src_o     = PC_JUMP;
                    reg_write_o  = opcode_i == OP_JAL;
                    reg_dst_o    = opcode_i == OP_JAL ? DST_RA : DST_RT;
                    mem_to_reg_o = opcode_i == OP_JAL ? WD_PC : WD_ALU;
                    next         = FETCH;
                end
                TRAP: begin
                    err_o = 1'b1;
                    next  = TRAP;
                end
                default: next = TRAP;
            endcase
    end

`ifdef MULTICYCLE_CTRL_PERF_EN
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            cyc_cnt_o <= '0;
            ins_cnt_o <= '0;
        end else begin
            cyc_cnt_o <= cyc_cnt_o + 1'b1;
            if (state != FETCH && next == FETCH) ins_cnt_o <= ins_cnt_o + 1'b1;
        end
`else
    assign cyc_cnt_o = '0;
    assign ins_cnt_o = '0;
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: table-driven per-cycle checks of the control FSM plus
// hand-written timeout, trap and asynchronous-reset sequences.
module tb_multicycle_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  op = '0, fn = '0;
    logic        z = 1'b0;
    logic        ir_write, pc_write, reg_write, alu_src_a, err;
    logic [1:0]  alu_src_b, pc_src, reg_dst, mem_to_reg;
    logic [2:0]  alu_op;
    logic [31:0] cyc_cnt, ins_cnt;
    int checks = 0, fails = 0;

`ifdef MULTICYCLE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    multicycle_ctrl_if bus();

    multicycle_ctrl #(.TIMEOUT_W(4), .CNT_W(32)) dut (
        .clk_i(clk), .rst_i(rst), .mem(bus), .opcode_i(op), .funct_i(fn), .zero_i(z),
        .ir_write_o(ir_write), .pc_write_o(pc_write), .reg_write_o(reg_write),
        .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b), .alu_op_o(alu_op),
        .pc_src_o(pc_src), .reg_dst_o(reg_dst), .mem_to_reg_o(mem_to_reg),
        .err_o(err), .cyc_cnt_o(cyc_cnt), .ins_cnt_o(ins_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic rd, wr, iord, irw, pcw, rw, a;
        logic [1:0] b;
        logic [2:0] op;
        logic [1:0] pcs, dst, m2r;
        logic err;
    } outs_t;
    typedef struct packed { outs_t e; outs_t m; } chk_t;
    typedef struct {
        string n;
        logic [5:0] op, fn;
        logic z, rdy;
        chk_t c;
        int ins;
    } vec_t;
    vec_t tv[$];

    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    function automatic outs_t en_m();
        outs_t m = '0;
        m.rd = 1; m.wr = 1; m.irw = 1; m.pcw = 1; m.rw = 1; m.err = 1;
        return m;
    endfunction
    function automatic chk_t s_fetch(logic r);
        chk_t c; c.e = '0; c.m = en_m();
        c.e.rd = 1; c.m.iord = 1; c.e.irw = r; c.e.pcw = r; c.e.b = 2'd1;
        if (r) begin c.m.a = 1; c.m.b = '1; c.m.pcs = '1; end
        return c;
    endfunction
    function automatic chk_t s_decode();
        chk_t c; c.e = '0; c.m = en_m();
        c.e.b = 2'd3; c.m.a = 1; c.m.b = '1;
        return c;
    endfunction
    function automatic chk_t s_quiet();
        chk_t c; c.e = '0; c.m = en_m();
        return c;
    endfunction
    function automatic chk_t s_mem(logic w);
        chk_t c; c.e = '0; c.m = en_m();
        c.e.rd = !w; c.e.wr = w; c.e.iord = 1; c.m.iord = 1;
        return c;
    endfunction
    function automatic chk_t s_wb(logic mem, logic [1:0] d);
        chk_t c; c.e = '0; c.m = en_m();
        c.e.rw = 1; c.e.m2r = mem ? 2'd1 : 2'd0; c.m.m2r = '1;
        c.e.dst = d; c.m.dst = '1;
        return c;
    endfunction
    function automatic chk_t s_pc(logic p, logic [1:0] src, logic jal);
        chk_t c; c.e = '0; c.m = en_m();
        c.e.pcw = p; c.e.pcs = src; c.m.pcs = '1;
        if (jal) begin c.e.rw = 1; c.e.dst = 2'd2; c.e.m2r = 2'd3; c.m.dst = '1; c.m.m2r = '1; end
        return c;
    endfunction
    function automatic chk_t s_trap();
        chk_t c; c.e = '0; c.m = en_m();
        c.e.err = 1;
        return c;
    endfunction

    task automatic add(string n, logic [5:0] o, logic [5:0] f, logic zz, logic r, chk_t c, int ins);
        vec_t v;
        v.n = n; v.op = o; v.fn = f; v.z = zz; v.rdy = r; v.c = c; v.ins = ins;
        tv.push_back(v);
    endtask

    function automatic outs_t cur();
        outs_t o;
        o = {bus.mem_read_o, bus.mem_write_o, bus.iord_o, ir_write, pc_write, reg_write,
             alu_src_a, alu_src_b, alu_op, pc_src, reg_dst, mem_to_reg, err};
        return o;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        outs_t a;
        bus.mem_ready_i = 1'b0;
        // lw with 2 fetch waits and 2 read waits
        add("lw_fetch", 35, 0, 0, 0, s_fetch(0), 0);
        add("lw_fetch", 35, 0, 0, 0, s_fetch(0), 0);
        add("lw_fetch", 35, 0, 0, 1, s_fetch(1), 0);
        add("lw_decode", 35, 0, 0, 0, s_decode(), 0);
        add("lw_addr", 35, 0, 0, 0, s_quiet(), 0);
        add("lw_rd", 35, 0, 0, 0, s_mem(0), 0);
        add("lw_rd", 35, 0, 0, 0, s_mem(0), 0);
        add("lw_rd", 35, 0, 0, 1, s_mem(0), 0);
        add("lw_wb", 35, 0, 0, 0, s_wb(1, 2'd0), 0);
        add("sw_fetch", 43, 0, 0, 1, s_fetch(1), 1);
        add("sw_decode", 43, 0, 0, 0, s_decode(), 1);
        add("sw_addr", 43, 0, 0, 0, s_quiet(), 1);
        add("sw_wr", 43, 0, 0, 0, s_mem(1), 1);
        add("sw_wr", 43, 0, 0, 1, s_mem(1), 1);
        add("r_fetch", 0, 33, 0, 1, s_fetch(1), 2);
        add("r_decode", 0, 33, 0, 0, s_decode(), 2);
        add("r_exec", 0, 33, 0, 0, s_quiet(), 2);
        add("r_wb", 0, 33, 0, 0, s_wb(0, 2'd1), 2);
        add("addi_fetch", 8, 0, 0, 1, s_fetch(1), 3);
        add("addi_decode", 8, 0, 0, 0, s_decode(), 3);
        add("addi_exec", 8, 0, 0, 0, s_quiet(), 3);
        add("addi_wb", 8, 0, 0, 0, s_wb(0, 2'd0), 3);
        add("beq_fetch", 4, 0, 0, 1, s_fetch(1), 4);
        add("beq_decode", 4, 0, 0, 0, s_decode(), 4);
        add("beq_nz", 4, 0, 0, 0, s_pc(0, 2'd1, 0), 4);
        add("bne_fetch", 5, 0, 0, 1, s_fetch(1), 5);
        add("bne_decode", 5, 0, 0, 0, s_decode(), 5);
        add("bne_nz", 5, 0, 0, 0, s_pc(1, 2'd1, 0), 5);
        add("beq_fetch", 4, 0, 1, 1, s_fetch(1), 6);
        add("beq_decode", 4, 0, 1, 0, s_decode(), 6);
        add("beq_z", 4, 0, 1, 0, s_pc(1, 2'd1, 0), 6);
        add("jal_fetch", 3, 0, 0, 1, s_fetch(1), 7);
        add("jal_decode", 3, 0, 0, 0, s_decode(), 7);
        add("jal", 3, 0, 0, 0, s_pc(1, 2'd2, 1), 7);
        add("j_fetch", 2, 0, 0, 1, s_fetch(1), 8);
        add("j_decode", 2, 0, 0, 0, s_decode(), 8);
        add("j", 2, 0, 0, 0, s_pc(1, 2'd2, 0), 8);
        add("jr_fetch", 0, 8, 0, 1, s_fetch(1), 9);
        add("jr_decode", 0, 8, 0, 0, s_decode(), 9);
        add("jr", 0, 8, 0, 0, s_pc(1, 2'd3, 0), 9);
        add("bad_fetch", 63, 0, 0, 1, s_fetch(1), 10);
        add("bad_decode", 63, 0, 0, 0, s_decode(), 10);
        add("trap", 63, 0, 0, 0, s_trap(), 10);
        add("trap_sticky", 63, 0, 0, 1, s_trap(), 10);

        repeat (2) @(negedge clk);
        #1;
        chk("rst_outs", 32'(cur()), 32'd0);
        chk("rst_cyc", cyc_cnt, 32'd0);
        chk("rst_ins", ins_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        foreach (tv[i]) begin
            op = tv[i].op; fn = tv[i].fn; z = tv[i].z; bus.mem_ready_i = tv[i].rdy;
            #1;
            a = cur();
            chk($sformatf("%s[%0d]", tv[i].n, i), 32'(a & tv[i].c.m), 32'(tv[i].c.e & tv[i].c.m));
            chk($sformatf("ins[%0d]", i), ins_cnt, PERF ? 32'(tv[i].ins) : 32'd0);
            chk($sformatf("cyc[%0d]", i), cyc_cnt, PERF ? 32'(i) : 32'd0);
            @(negedge clk);
        end

        // trap left only by reset
        #1 chk("trap_hold", {31'd0, err}, 32'd1);
        #1 rst = 1'b1;
        #1 chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_cnt", cyc_cnt | ins_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b0; bus.mem_ready_i = 1'b0;

        // 15 tolerated wait cycles, trap when the counter is at max and still not ready
        for (int i = 0; i < 16; i++) begin
            #1 chk($sformatf("to_wait[%0d]", i), {30'd0, bus.mem_read_o, err}, 32'd2);
            @(negedge clk);
        end
        #1 chk("to_trap", {30'd0, bus.mem_read_o, err}, 32'd1);
        bus.mem_ready_i = 1'b1;
        @(negedge clk);
        #1 chk("to_sticky", {30'd0, bus.mem_read_o, err}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; bus.mem_ready_i = 1'b0; op = 43;

        // ready arriving when the counter is at max wins
        repeat (15) @(negedge clk);
        bus.mem_ready_i = 1'b1;
        #1 chk("edge_ready", {30'd0, ir_write, pc_write}, 32'd3);
        @(negedge clk);
        bus.mem_ready_i = 1'b0;
        #1 chk("edge_decode", {29'd0, err, alu_src_b}, 32'd3);
        @(negedge clk);
        #1 chk("sw_addr2", {31'd0, bus.mem_write_o}, 32'd0);
        @(negedge clk);
        #1 chk("sw_wait", {30'd0, bus.mem_write_o, bus.iord_o}, 32'd3);
        #1 rst = 1'b1;
        #1 chk("rst_abandon", {30'd0, bus.mem_write_o, bus.mem_read_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0; bus.mem_ready_i = 1'b1;
        #1 chk("resume_fetch", {29'd0, bus.mem_read_o, bus.iord_o, ir_write}, 32'd5);
        @(negedge clk);
        bus.mem_ready_i = 1'b0;
        #1 chk("resume_decode", {30'd0, alu_src_b}, 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
